// File: rtl/latch_edge_capture.sv
// latch_edge_capture: synchronizes and debounces an async level, flags edges, counts them and queues one event.
// Optional LATCH_EDGE_CAPTURE_TS_EN adds a 16-bit cycle timestamp (evt_ts) to each loaded event.
module latch_edge_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_in,
    input  logic             clr_count,
    input  logic             evt_ready,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_count,
    output logic             evt_valid,
    output logic             evt_type,
`ifdef LATCH_EDGE_CAPTURE_TS_EN
    output logic [15:0]      evt_ts,
`endif
    output logic             overflow
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [0:0] STABLE = 1'b0;
    localparam logic [0:0] CHECK  = 1'b1;

    logic [SYNC_STAGES-1:0] sync;
    logic [0:0]             state, nstate;
    logic [DW-1:0]          cnt, ncnt;
    logic                   s, diff, accept, load;

    assign s = sync[SYNC_STAGES-1];

    // Any mismatch that is not yet accepted keeps (or starts) the run in CHECK.
    always_comb begin
        diff   = s != level_out;
        accept = diff && ((state == CHECK) ? (cnt == DW'(DEBOUNCE - 1)) : (DEBOUNCE == 1));
        nstate = (diff && !accept) ? CHECK : STABLE;
        ncnt   = (diff && !accept) ? cnt + DW'(1) : '0;
        load   = accept && (!evt_valid || evt_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync       <= '0;
            state      <= STABLE;
            cnt        <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            edge_count <= '0;
            evt_valid  <= 1'b0;
            evt_type   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], d_in};
            state      <= nstate;
            cnt        <= ncnt;
            level_out  <= level_out ^ accept;
            rise_pulse <= accept & ~level_out;
            fall_pulse <= accept & level_out;
            edge_count <= clr_count ? '0 : edge_count + CNT_W'(accept);
            evt_valid  <= load | (evt_valid & ~evt_ready);
            overflow   <= overflow | (accept & evt_valid & ~evt_ready);
            if (load) evt_type <= ~level_out;
        end
    end

`ifdef LATCH_EDGE_CAPTURE_TS_EN
    logic [15:0] ts_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt <= '0;
            evt_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
            if (load) evt_ts <= ts_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_latch_edge_capture.sv
// tb_latch_edge_capture: directed plus randomized checks against a run-length reference model.
module tb_latch_edge_capture;
    localparam int SS = 2;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       d_in = 1'b0;
    logic       clr_count = 1'b0;
    logic       evt_ready = 1'b0;
    logic       level_out, rise_pulse, fall_pulse, evt_valid, evt_type, overflow;
    logic [7:0] edge_count;
`ifdef LATCH_EDGE_CAPTURE_TS_EN
    logic [15:0] evt_ts;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: delay line for the synchronizer, run length of mismatching samples for debounce.
    logic        m_hist [SS];
    logic        m_level, m_rise, m_fall, m_valid, m_type, m_ovf;
    logic [7:0]  m_cnt;
    logic [15:0] m_tscnt, m_ts;
    int          m_run;

    latch_edge_capture #(.SYNC_STAGES(SS), .DEBOUNCE(DB), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .clr_count(clr_count), .evt_ready(evt_ready),
        .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .edge_count(edge_count), .evt_valid(evt_valid), .evt_type(evt_type),
`ifdef LATCH_EDGE_CAPTURE_TS_EN
        .evt_ts(evt_ts),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_hist[i] = 1'b0;
        m_level = 0; m_rise = 0; m_fall = 0; m_valid = 0; m_type = 0; m_ovf = 0;
        m_cnt = 0; m_tscnt = 0; m_ts = 0; m_run = 0;
    endtask

    task automatic model_step();
        logic s, acc, pushable;
        s = m_hist[SS-1];
        for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = d_in;
        acc = 1'b0;
        if (s != m_level) begin
            m_run++;
            if (m_run == DB) begin
                acc = 1'b1;
                m_run = 0;
            end
        end else m_run = 0;
        if (acc) m_level = ~m_level;
        m_rise = acc && m_level;
        m_fall = acc && !m_level;
        m_cnt = clr_count ? 8'd0 : m_cnt + (acc ? 8'd1 : 8'd0);
        pushable = !m_valid || evt_ready;
        if (acc && pushable) begin
            m_valid = 1'b1;
            m_type = m_level;
            m_ts = m_tscnt;
        end else if (acc) m_ovf = 1'b1;
        else if (m_valid && evt_ready) m_valid = 1'b0;
        m_tscnt = m_tscnt + 16'd1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"}, {15'd0, level_out}, {15'd0, m_level});
        chk({tag, ".rise"}, {15'd0, rise_pulse}, {15'd0, m_rise});
        chk({tag, ".fall"}, {15'd0, fall_pulse}, {15'd0, m_fall});
        chk({tag, ".count"}, {8'd0, edge_count}, {8'd0, m_cnt});
        chk({tag, ".valid"}, {15'd0, evt_valid}, {15'd0, m_valid});
        if (m_valid) chk({tag, ".type"}, {15'd0, evt_type}, {15'd0, m_type});
        chk({tag, ".ovf"}, {15'd0, overflow}, {15'd0, m_ovf});
`ifdef LATCH_EDGE_CAPTURE_TS_EN
        if (m_valid) chk({tag, ".ts"}, evt_ts, m_ts);
`endif
    endtask

    task automatic tick(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all(tag);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".level"}, {15'd0, level_out}, 16'd0);
        chk({tag, ".rise"}, {15'd0, rise_pulse}, 16'd0);
        chk({tag, ".fall"}, {15'd0, fall_pulse}, 16'd0);
        chk({tag, ".count"}, {8'd0, edge_count}, 16'd0);
        chk({tag, ".valid"}, {15'd0, evt_valid}, 16'd0);
        chk({tag, ".type"}, {15'd0, evt_type}, 16'd0);
        chk({tag, ".ovf"}, {15'd0, overflow}, 16'd0);
`ifdef LATCH_EDGE_CAPTURE_TS_EN
        chk({tag, ".ts"}, evt_ts, 16'd0);
`endif
    endtask

    initial begin
        // Reset with d_in high, then the rise must land on the sixth edge.
        model_reset();
        d_in = 1'b1;
        #1 rst = 1'b1;
        #1 check_zero("rst_async");
        @(negedge clk);
        @(negedge clk);
        check_zero("rst_held");
        rst = 1'b0;
        tick("rise_lat", 5);
        chk("rise_lat.pre", {15'd0, level_out}, 16'd0);
        tick("rise_lat", 1);
        chk("rise_lat.level", {15'd0, level_out}, 16'd1);
        chk("rise_lat.pulse", {15'd0, rise_pulse}, 16'd1);
        tick("rise_lat", 1);
        chk("rise_lat.pulse1", {15'd0, rise_pulse}, 16'd0);
        chk("rise_lat.valid", {15'd0, evt_valid}, 16'd1);
        chk("rise_lat.type", {15'd0, evt_type}, 16'd1);
        chk("rise_lat.count", {8'd0, edge_count}, 16'd1);

        // Pop and push in the same cycle as the fall is accepted.
        d_in = 1'b0;
        tick("popush", 5);
        evt_ready = 1'b1;
        tick("popush", 1);
        chk("popush.fall", {15'd0, fall_pulse}, 16'd1);
        chk("popush.valid", {15'd0, evt_valid}, 16'd1);
        chk("popush.type", {15'd0, evt_type}, 16'd0);
        chk("popush.ovf", {15'd0, overflow}, 16'd0);
        tick("popush", 1);
        chk("popush.drain", {15'd0, evt_valid}, 16'd0);
        evt_ready = 1'b0;

        // Three-cycle glitch is filtered out.
        d_in = 1'b1;
        tick("glitch", 3);
        d_in = 1'b0;
        tick("glitch", 10);
        chk("glitch.level", {15'd0, level_out}, 16'd0);
        chk("glitch.count", {8'd0, edge_count}, 16'd2);
        chk("glitch.valid", {15'd0, evt_valid}, 16'd0);

        // Backpressure: second event is dropped and overflow sticks.
        d_in = 1'b1;
        tick("bp", 8);
        d_in = 1'b0;
        tick("bp", 8);
        chk("bp.type", {15'd0, evt_type}, 16'd1);
        chk("bp.ovf", {15'd0, overflow}, 16'd1);
        chk("bp.count", {8'd0, edge_count}, 16'd4);
        evt_ready = 1'b1;
        tick("bp", 1);
        evt_ready = 1'b0;
        chk("bp.pop", {15'd0, evt_valid}, 16'd0);
        tick("bp", 2);
        chk("bp.ovf_sticky", {15'd0, overflow}, 16'd1);

        // 256 accepted edges wrap the 8-bit counter back to zero.
        clr_count = 1'b1;
        tick("clr", 1);
        clr_count = 1'b0;
        chk("clr.count", {8'd0, edge_count}, 16'd0);
        for (int k = 0; k < 256; k++) begin
            d_in = ~d_in;
            evt_ready = 1'($urandom_range(0, 1));
            tick("wrap", 6);
        end
        evt_ready = 1'b0;
        chk("wrap.count", {8'd0, edge_count}, 16'd0);
        tick("wrap", 1);
        d_in = ~d_in;
        tick("clr_acc", 5);
        clr_count = 1'b1;
        tick("clr_acc", 1);
        clr_count = 1'b0;
        chk("clr_acc.level", {15'd0, level_out}, {15'd0, d_in});
        chk("clr_acc.count", {8'd0, edge_count}, 16'd0);

        // Randomized traffic with glitches of varied length.
        for (int k = 0; k < 300; k++) begin
            d_in = ($urandom_range(0, 3) == 0) ? ~d_in : d_in;
            evt_ready = ($urandom_range(0, 2) == 0);
            clr_count = ($urandom_range(0, 40) == 0);
            tick("rand", $urandom_range(1, 5));
        end
        clr_count = 1'b0;

        // Reset in CHECK with an event held and overflow set.
        evt_ready = 1'b0;
        d_in = ~level_out;
        tick("mid", 8);
        d_in = ~d_in;
        tick("mid", 8);
        chk("mid.valid", {15'd0, evt_valid}, 16'd1);
        chk("mid.ovf", {15'd0, overflow}, 16'd1);
        d_in = ~d_in;
        tick("mid", 3);
        #2 rst = 1'b1;
        #1 check_zero("mid_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        d_in = 1'b1;
        tick("post", 5);
        chk("post.pre", {15'd0, level_out}, 16'd0);
        tick("post", 1);
        chk("post.level", {15'd0, level_out}, 16'd1);
        chk("post.rise", {15'd0, rise_pulse}, 16'd1);
        tick("post", 2);
        chk("post.count", {8'd0, edge_count}, 16'd1);
        chk("post.ovf", {15'd0, overflow}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
